ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Sequential successor to the combinational scancode converter.
- Consumes PS/2 set-2 bytes from the PS/2 receiver one strobe at a time and tracks E0 (extended) and F0 (break) prefixes with a state machine.
- Maintains held-key levels for the four arrow keys.
- Pushes completed key events, with WASD codes translated to ASCII, into a parametrised show-ahead FIFO read by the processor's I/O path.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; must be a power of two, minimum 2.
- CODE_W, 8, scancode and translated-code width; values above 8 zero-extend the code field.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- scan_data  in  8  received scancode byte.
- scan_valid  in  1  one-cycle strobe; scan_data is valid this cycle.
- evt_data  out  CODE_W+2  head event {is_break, is_ext, code[CODE_W-1:0]}.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  pop head this cycle; ignored when evt_valid=0.
- key_up  out  1  up arrow held.
- key_down  out  1  down arrow held.
- key_left  out  1  left arrow held.
- key_right  out  1  right arrow held.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- clear_ovf  in  1  one-cycle pulse; clears overflow.

Behaviour:
- Reset, asynchronous, active-high:
  - FSM goes to IDLE; FIFO pointers and count go to 0.
  - evt_valid=0, evt_data=0, key_*=0, overflow=0.
  - Reset asserted mid-sequence, e.g. after E0 F0, discards the partial prefix.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only on cycles with scan_valid=1:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte completes a make code and returns to IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT (redundant prefix absorbed); any other byte completes an extended make code -> IDLE.
  - BRK: E0 -> EXT_BRK (out-of-order prefix tolerated); F0 -> BRK; any other byte completes a break code -> IDLE.
  - EXT_BRK: E0 or F0 -> EXT_BRK; any other byte completes an extended break code -> IDLE.
- Code translation on completion:
  - 1D -> 87 ('W'), 1B -> 83 ('S'), 1C -> 65 ('A'), 23 -> 68 ('D').
  - All other bytes pass through unchanged.
  - is_ext and is_break come from the FSM state.
- Held keys:
  - Codes 75 (up), 72 (down), 6B (left), 74 (right) are recognised with or without an E0 prefix.
  - A make sets the matching key_* bit; a break clears it.
  - Flags update regardless of FIFO state.
- Latency: when the final byte's scan_valid arrives in cycle N, key_* and the FIFO write both take effect at the clock edge ending N. evt_valid is therefore 1 in cycle N+1 if the FIFO was empty.
- FIFO:
  - Show-ahead: evt_data always shows the head entry.
  - A pop takes effect on the clock edge where evt_valid and evt_ready are both 1.
  - Push when full with no pop: the event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both are accepted and the count is unchanged.
  - Push and pop in the same cycle while empty: only the push occurs, since evt_valid=0.
  - Pointers wrap modulo FIFO_DEPTH; a log2(FIFO_DEPTH)+1 count distinguishes full from empty.
- overflow:
  - clear_ovf clears it.
  - If a drop and clear_ovf occur in the same cycle, set wins and overflow stays 1.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - Four internal held bits track W, S, A and D.
  - A repeated make for a key whose held bit is already 1 (arrows or WASD) is not pushed to the FIFO.
  - Break codes are always pushed.
- Undefined: every completed code is pushed, including typematic repeats.

Test Plan:
- Reset, then send bytes 1D -> one event {0,0,87}; key_* all 0; evt_valid=1 the cycle after the strobe.
- Send E0 75, then E0 F0 75 -> key_up goes 1 after 75 and back to 0 after the final 75; events {0,1,0x75} then {1,1,0x75}.
- Send F0 1C -> event {1,0,65}; FSM returns to IDLE, so a following 23 yields {0,0,68}.
- With evt_ready=0, push FIFO_DEPTH+1 make codes -> FIFO_DEPTH events retained in order; overflow=1. A clear_ovf pulse -> overflow=0.
- With the FIFO full, assert evt_ready together with a new code's scan_valid -> count stays FIFO_DEPTH and the newest code is at the tail; overflow unchanged.
- Assert reset between E0 and 74 -> a subsequent 74 is decoded as non-extended {0,0,0x74} and key_right=1. With PS2_TYPEMATIC_FILTER_EN, three further 74 bytes produce no events.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: prefix FSM, arrow-key hold levels and a show-ahead event FIFO.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of already-held keys.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CODE_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        scan_data,
    input  logic              scan_valid,
    output logic [CODE_W+1:0] evt_data,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic              key_up,
    output logic              key_down,
    output logic              key_left,
    output logic              key_right,
    output logic              overflow,
    input  logic              clear_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    function automatic logic [7:0] translate(input logic [7:0] b);
        case (b)
            8'h1D:   translate = 8'd87;
            8'h1B:   translate = 8'd83;
            8'h1C:   translate = 8'd65;
            8'h23:   translate = 8'd68;
            default: translate = b;
        endcase
    endfunction

    state_t              state, state_next;
    logic                done, is_ext, is_break;
    logic [CODE_W-1:0]   code;
    logic [3:0]          keys, arrow_hit, wasd_hit;
    logic                repeat_make, push, pop, full, push_ok, drop;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [CODE_W+1:0]   mem [FIFO_DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        is_ext     = (state == EXT) || (state == EXT_BRK);
        is_break   = (state == BRK) || (state == EXT_BRK);
        if (scan_valid) begin
            case (state)
                IDLE:    if (scan_data == 8'hE0) state_next = EXT;
                         else if (scan_data == 8'hF0) state_next = BRK;
                         else done = 1'b1;
                EXT:     if (scan_data == 8'hF0) state_next = EXT_BRK;
                         else if (scan_data == 8'hE0) state_next = EXT;
                         else begin done = 1'b1; state_next = IDLE; end
                BRK:     if (scan_data == 8'hE0) state_next = EXT_BRK;
                         else if (scan_data == 8'hF0) state_next = BRK;
                         else begin done = 1'b1; state_next = IDLE; end
                default: if (scan_data == 8'hE0 || scan_data == 8'hF0) state_next = EXT_BRK;
                         else begin done = 1'b1; state_next = IDLE; end
            endcase
        end
    end

    assign code      = CODE_W'(translate(scan_data));
    assign arrow_hit = {scan_data == 8'h75, scan_data == 8'h72, scan_data == 8'h6B, scan_data == 8'h74};
    assign wasd_hit  = {scan_data == 8'h1D, scan_data == 8'h1B, scan_data == 8'h1C, scan_data == 8'h23};

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [3:0] wasd_held;
    assign repeat_make = !is_break && ((|(arrow_hit & keys)) || (|(wasd_hit & wasd_held)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)     wasd_held <= '0;
        else if (done) wasd_held <= is_break ? (wasd_held & ~wasd_hit) : (wasd_held | wasd_hit);
    end
`else
    assign repeat_make = 1'b0;
`endif

    assign push    = done && !repeat_make;
    assign full    = (count == CW'(FIFO_DEPTH));
    assign evt_valid = (count != '0);
    assign pop     = evt_valid && evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            keys     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
            if (done) keys <= is_break ? (keys & ~arrow_hit) : (keys | arrow_hit);
            if (drop)           overflow <= 1'b1;
            else if (clear_ovf) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= {is_break, is_ext, code};
    end

    assign evt_data  = evt_valid ? mem[rd_ptr] : '0;
    assign key_up    = keys[3];
    assign key_down  = keys[2];
    assign key_left  = keys[1];
    assign key_right = keys[0];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: fixed vector table, hand sequences and a random run
// checked against a queue-based event model.
module tb_ps2_key_decoder;

    localparam int DEPTH = 8;
    localparam int CW    = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    scan_data = '0;
    logic          scan_valid = 1'b0;
    logic [CW+1:0] evt_data;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic          key_up, key_down, key_left, key_right;
    logic          overflow;
    logic          clear_ovf = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .CODE_W(CW)) dut (
        .clock(clock), .reset(reset), .scan_data(scan_data), .scan_valid(scan_valid),
        .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .overflow(overflow), .clear_ovf(clear_ovf)
    );

    always #5 clock = ~clock;

    // Reference model: a queue of pending events plus prefix and hold flags.
    logic [CW+1:0] mq[$];
    bit            m_ext, m_brk, m_ovf;
    logic [3:0]    m_keys, m_wasd;

    function automatic logic [7:0] ascii_of(input logic [7:0] b);
        case (b)
            8'h1D:   return 8'd87;
            8'h1B:   return 8'd83;
            8'h1C:   return 8'd65;
            8'h23:   return 8'd68;
            default: return b;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0; m_keys = '0; m_wasd = '0;
    endtask

    task automatic model_edge(input bit sv, input logic [7:0] b, input bit rdy, input bit clr);
        bit drop = 0;
        bit rep  = 0;
        int ai = -1;
        int wi = -1;
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (sv) begin
            if (b == 8'hE0) m_ext = 1;
            else if (b == 8'hF0) m_brk = 1;
            else begin
                case (b) 8'h75: ai = 3; 8'h72: ai = 2; 8'h6B: ai = 1; 8'h74: ai = 0; default: ai = -1; endcase
                case (b) 8'h1D: wi = 3; 8'h1B: wi = 2; 8'h1C: wi = 1; 8'h23: wi = 0; default: wi = -1; endcase
`ifdef PS2_TYPEMATIC_FILTER_EN
                rep = !m_brk && ((ai >= 0 && m_keys[ai]) || (wi >= 0 && m_wasd[wi]));
`endif
                if (ai >= 0) m_keys[ai] = !m_brk;
                if (wi >= 0) m_wasd[wi] = !m_brk;
                if (!rep) begin
                    if (mq.size() < DEPTH) mq.push_back({m_brk, m_ext, ascii_of(b)});
                    else drop = 1;
                end
                m_ext = 0; m_brk = 0;
            end
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [CW+1:0] head;
        head = (mq.size() > 0) ? mq[0] : '0;
        check("model_valid", 32'(evt_valid), 32'(mq.size() > 0));
        check("model_data", 32'(evt_data), 32'(head));
        check("model_keys", 32'({key_up, key_down, key_left, key_right}), 32'(m_keys));
        check("model_ovf", 32'(overflow), 32'(m_ovf));
    endtask

    // Inputs are applied 1 time unit after a rising edge and held for one full cycle.
    task automatic step(input bit sv, input logic [7:0] b, input bit rdy, input bit clr);
        scan_valid = sv; scan_data = b; evt_ready = rdy; clear_ovf = clr;
        @(posedge clock);
        model_edge(sv, b, rdy, clr);
        #1;
        scan_valid = 0; evt_ready = 0; clear_ovf = 0;
        check_model();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_data", 32'(evt_data), 32'd0);
        check("rst_keys", 32'({key_up, key_down, key_left, key_right}), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0]    b;
        bit            rdy;
        bit            clr;
        bit            valid;
        logic [CW+1:0] data;
        logic [3:0]    keys;
        bit            ovf;
    } vec_t;

    vec_t tbl[17];
    logic [7:0] pool[12];
    logic [CW+1:0] exp_order[8];

    initial begin
        int drained;
        tbl[0]  = '{8'h1D, 1'b0, 1'b0, 1'b1, 10'h057, 4'b0000, 1'b0};
        tbl[1]  = '{8'hE0, 1'b1, 1'b0, 1'b0, 10'h000, 4'b0000, 1'b0};
        tbl[2]  = '{8'h75, 1'b0, 1'b0, 1'b1, 10'h175, 4'b1000, 1'b0};
        tbl[3]  = '{8'hE0, 1'b1, 1'b0, 1'b0, 10'h000, 4'b1000, 1'b0};
        tbl[4]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 4'b1000, 1'b0};
        tbl[5]  = '{8'h75, 1'b0, 1'b0, 1'b1, 10'h375, 4'b0000, 1'b0};
        tbl[6]  = '{8'hF0, 1'b1, 1'b0, 1'b0, 10'h000, 4'b0000, 1'b0};
        tbl[7]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h241, 4'b0000, 1'b0};
        tbl[8]  = '{8'h23, 1'b1, 1'b0, 1'b1, 10'h044, 4'b0000, 1'b0};
        tbl[9]  = '{8'h74, 1'b1, 1'b0, 1'b1, 10'h074, 4'b0001, 1'b0};
        tbl[10] = '{8'hF0, 1'b1, 1'b0, 1'b0, 10'h000, 4'b0001, 1'b0};
        tbl[11] = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 4'b0001, 1'b0};
        tbl[12] = '{8'h74, 1'b0, 1'b0, 1'b1, 10'h374, 4'b0000, 1'b0};
        tbl[13] = '{8'h6B, 1'b1, 1'b0, 1'b1, 10'h06B, 4'b0010, 1'b0};
        tbl[14] = '{8'h72, 1'b1, 1'b0, 1'b1, 10'h072, 4'b0110, 1'b0};
        tbl[15] = '{8'hF0, 1'b1, 1'b0, 1'b0, 10'h000, 4'b0110, 1'b0};
        tbl[16] = '{8'h6B, 1'b0, 1'b0, 1'b1, 10'h26B, 4'b0100, 1'b0};
        pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0};

        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("por_valid", 32'(evt_valid), 32'd0);
        check("por_data", 32'(evt_data), 32'd0);
        check("por_keys", 32'({key_up, key_down, key_left, key_right}), 32'd0);
        check("por_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step(1'b1, tbl[i].b, tbl[i].rdy, tbl[i].clr);
            check($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(tbl[i].valid));
            check($sformatf("vec%0d_data", i), 32'(evt_data), 32'(tbl[i].data));
            check($sformatf("vec%0d_keys", i), 32'({key_up, key_down, key_left, key_right}), 32'(tbl[i].keys));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
        end

        // Overflow, drop-versus-clear priority and push/pop while full.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head", 32'(evt_data), 32'h010);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clear", 32'(overflow), 32'd0);
        step(1'b1, 8'h40, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h30, 1'b1, 1'b0);
        check("full_pp_ovf", 32'(overflow), 32'd0);
        check("full_pp_head", 32'(evt_data), 32'h011);
        for (int k = 0; k < 7; k++) exp_order[k] = 10'(10'h011 + k);
        exp_order[7] = 10'h030;
        drained = 0;
        for (int k = 0; k < 20 && evt_valid; k++) begin
            if (k < 8) check($sformatf("drain%0d", k), 32'(evt_data), 32'(exp_order[k]));
            step(1'b0, 8'h00, 1'b1, 1'b0);
            drained++;
        end
        check("drain_count", 32'(drained), 32'(DEPTH));

        // Reset between E0 and 74 discards the prefix.
        do_reset();
        step(1'b1, 8'hE0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 8'h74, 1'b0, 1'b0);
        check("rstmid_data", 32'(evt_data), 32'h074);
        check("rstmid_right", 32'(key_right), 32'd1);
        repeat (3) step(1'b1, 8'h74, 1'b0, 1'b0);
        drained = 0;
        for (int k = 0; k < 10 && evt_valid; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            drained++;
        end
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("typematic_events", 32'(drained), 32'd1);
`else
        check("typematic_events", 32'(drained), 32'd4);
`endif

        // Randomised traffic against the model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 11)];
            step($urandom_range(0, 9) < 6, b, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
